// File: rtl/mtm_riscv_soc_timer.sv
// Memory-mapped timer: prescaled free-running counter, compare match, level irq.
// Single-cycle bus slave, never stalls, one registered response per request.
module mtm_riscv_soc_timer #(
    parameter int CNT_WIDTH   = 32,
    parameter int PRESC_WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    output logic        gnt,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [3:0]  be,
    input  logic [31:0] wdata,
    output logic        rvalid,
    output logic        err,
    output logic [31:0] rdata,
    output logic        irq
);

    logic                   en;
    logic                   irq_en;
    logic                   auto_clr;
    logic [PRESC_WIDTH-1:0] presc;
    logic [PRESC_WIDTH-1:0] presc_cnt;
    logic [CNT_WIDTH-1:0]   count;
    logic [CNT_WIDTH-1:0]   cmp;
    logic                   match;

    logic [11:0] off;
    logic        sel_ctrl;
    logic        sel_count;
    logic        sel_cmp;
    logic        sel_status;
    logic        bad;
    logic        wr;
    logic [31:0] wmask;
    logic [31:0] ctrl_val;
    logic [31:0] count_ext;
    logic [31:0] cmp_ext;
    logic [31:0] ctrl_wval;
    logic [31:0] count_wval;
    logic [31:0] cmp_wval;
    logic [31:0] rd_mux;
    logic        ctrl_wr;
    logic        count_wr;
    logic        cmp_wr;
    logic        match_clr;
    logic        presc_clr;
    logic        tick;
    logic        cmp_hit;
    logic        unused;

    assign gnt = req;

    assign off        = addr[11:0];
    assign sel_ctrl   = (off == 12'h000);
    assign sel_count  = (off == 12'h004);
    assign sel_cmp    = (off == 12'h008);
    assign sel_status = (off == 12'h00C);
    assign bad        = !(sel_ctrl || sel_count || sel_cmp || sel_status);

    assign wr    = req && we && !bad;
    assign wmask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};

    always_comb begin
        ctrl_val                  = '0;
        ctrl_val[0]               = en;
        ctrl_val[1]               = irq_en;
        ctrl_val[2]               = auto_clr;
        ctrl_val[8+:PRESC_WIDTH]  = presc;
    end

    assign count_ext = 32'(count);
    assign cmp_ext   = 32'(cmp);

    // Byte-merged write values; unmasked lanes keep the current contents.
    assign ctrl_wval  = (ctrl_val & ~wmask) | (wdata & wmask);
    assign count_wval = (count_ext & ~wmask) | (wdata & wmask);
    assign cmp_wval   = (cmp_ext & ~wmask) | (wdata & wmask);

    assign ctrl_wr   = wr && sel_ctrl;
    assign count_wr  = wr && sel_count;
    assign cmp_wr    = wr && sel_cmp;
    assign match_clr = wr && sel_status && be[0] && wdata[0];

    assign presc_clr = ctrl_wr &&
        ((ctrl_wval[8+:PRESC_WIDTH] != presc) || (en && !ctrl_wval[0]));

    assign tick    = en && (presc_cnt == presc);
    assign cmp_hit = (count == cmp);

    always_comb begin
        rd_mux = '0;
        case (off)
            12'h000: rd_mux = ctrl_val;
            12'h004: rd_mux = count_ext;
            12'h008: rd_mux = cmp_ext;
            12'h00C: rd_mux = {31'b0, match};
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid <= 1'b0;
            err    <= 1'b0;
            rdata  <= '0;
        end else begin
            rvalid <= req;
            err    <= req && bad;
            rdata  <= (req && !we && !bad) ? rd_mux : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en       <= 1'b0;
            irq_en   <= 1'b0;
            auto_clr <= 1'b0;
            presc    <= '0;
        end else if (ctrl_wr) begin
            en       <= ctrl_wval[0];
            irq_en   <= ctrl_wval[1];
            auto_clr <= ctrl_wval[2];
            presc    <= ctrl_wval[8+:PRESC_WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_cnt <= '0;
        end else if (!en || presc_clr || tick) begin
            presc_cnt <= '0;
        end else begin
            presc_cnt <= presc_cnt + PRESC_WIDTH'(1);
        end
    end

    // A bus write to COUNT overrides the tick update; MATCH still uses the old COUNT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (count_wr) begin
            count <= count_wval[CNT_WIDTH-1:0];
        end else if (tick) begin
            count <= (cmp_hit && auto_clr) ? '0 : count + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp <= '0;
        end else if (cmp_wr) begin
            cmp <= cmp_wval[CNT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match <= 1'b0;
            irq   <= 1'b0;
        end else begin
            if (tick && cmp_hit) begin
                match <= 1'b1;
            end else if (match_clr) begin
                match <= 1'b0;
            end
            irq <= match && irq_en;
        end
    end

    assign unused = ^{addr[31:12], ctrl_wval, count_wval, cmp_wval};

endmodule

// File: doc/mtm_riscv_soc_timer.md
Name: mtm_riscv_soc_timer

Overview:
- Memory-mapped timer peripheral; data-bus slave in the 4 kB window at 0x0100_3000–0x0100_3FFF.
- Fed by the SoC data-bus decoder; answers with req/gnt/rvalid/err handshake.
- Provides free-running prescaled counter, compare match flag, level interrupt to core.

Parameters:
- CNT_WIDTH, 32, counter/compare width (1..32); reads zero-extended to 32 bits.
- PRESC_WIDTH, 8, prescaler field width (1..8).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req  in  1  bus request from decoder
- gnt  out  1  grant
- addr  in  32  byte address; only addr[11:0] decoded
- we  in  1  1=write, 0=read
- be  in  4  byte enables
- wdata  in  32  write data
- rvalid  out  1  response valid
- err  out  1  error response, valid with rvalid
- rdata  out  32  read data, valid with rvalid
- irq  out  1  timer interrupt, level, active-high

Behaviour:
- Reset: clk, rst_n: one clock; reset asynchronous, active-low. All registers 0; gnt=0 not required (combinational), rvalid=0, err=0, rdata=0, irq=0, prescaler counter 0.
- Handshake: gnt = req (combinational, never stalls). Accept on req&gnt. Exactly one response: rvalid=1 the cycle after accept, for one cycle. Back-to-back accepts give back-to-back rvalid.
- err/rdata registered with rvalid; rdata=0 on writes and on err.
- Register map (addr[11:0]):
  - 0x000 CTRL: [0] EN, [1] IRQ_EN, [2] AUTO_CLR, [8+:PRESC_WIDTH] PRESC; other bits RAZ/WI.
  - 0x004 COUNT: RW.
  - 0x008 CMP: RW.
  - 0x00C STATUS: [0] MATCH; write-1-to-clear.
  - Any other offset, or addr[1:0]!=0 → err=1, no state change.
- Byte enables: each written byte updates only when its be bit set; be=0 write is a legal no-op (err=0).
- Prescaler: when EN=1, presc_cnt increments each cycle; when presc_cnt==PRESC, tick=1 and presc_cnt←0. PRESC=0 → tick every cycle. EN=0 → presc_cnt held at 0, no ticks.
- Tick:
  - If COUNT==CMP: MATCH←1, and COUNT←0 if AUTO_CLR else COUNT+1.
  - Otherwise COUNT←COUNT+1, wrapping 2^CNT_WIDTH−1 → 0.
- Simultaneous events:
  - Bus write to COUNT in same cycle as tick → written value wins; compare evaluated on pre-write COUNT only for MATCH.
  - W1C of MATCH same cycle as new match → MATCH stays 1 (set wins).
  - Write to CTRL that changes PRESC or clears EN resets presc_cnt to 0.
- irq: registered; irq ← MATCH & IRQ_EN (one-cycle lag from MATCH/IRQ_EN change).
- Reset asserted mid-transaction: pending rvalid dropped, all state to reset values immediately.

Test Plan:
- Reset then read 0x004 → gnt same cycle, rvalid next cycle, rdata=0, err=0; irq=0.
- Write CMP=5, CTRL=0x0007 (EN, IRQ_EN, AUTO_CLR, PRESC=0) → COUNT 0..5, MATCH=1 on 6th tick, COUNT→0, irq high one cycle later; W1C 0x00C=1 → irq low next+1 cycle.
- CTRL PRESC=3, EN=1, AUTO_CLR=0 → COUNT increments every 4 cycles; preset COUNT=0xFFFF_FFFF, CMP=0x10 → wraps to 0, MATCH stays 0.
- Write 0x004 wdata=0xAABBCCDD be=0b0101 over COUNT=0 with EN=0 → read returns 0x00BB00DD.
- Read 0x010 and write 0x006 → rvalid with err=1, rdata=0, no register changes.
- W1C STATUS issued in tick cycle that matches → MATCH remains 1; COUNT write coinciding with tick → COUNT equals written value.
